clock_panel_ctrl: RTL and testbench

//  Front-panel driver for the clock generator's control inputs. Takes three raw, bouncy push-buttons
//  (start/stop, step, speed) and produces clean, glitch-free control signals for the clock generator.

---
 rtl/clock_panel_pkg.sv | 13 +
 rtl/clock_panel_ctrl_if.sv | 26 ++
 rtl/button_debounce.sv | 58 +++++
 rtl/clock_panel_ctrl.sv | 111 +++++++++++
 tb/tb_clock_panel_ctrl.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/clock_panel_pkg.sv
// Shared types and constants for the front-panel clock controller.
// Provides the speed index type, the clock generator's power-up mirror values
// and default timing constants.
package clock_panel_pkg;

  typedef logic [1:0] speed_idx_t;

  localparam speed_idx_t  SPEED_IDX_RESET         = 2'd0;
  localparam logic        RUNNING_RESET           = 1'b1;
  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 250000;
  localparam int unsigned PULSE_CYCLES_DEFAULT    = 4;

endpackage

// File: rtl/clock_panel_ctrl_if.sv
// Panel-side signal bundle: raw buttons in, clean clock-generator controls
// and status mirrors out.
//   master : the panel controller (samples buttons, drives controls/status)
//   slave  : board/top level (drives buttons, consumes controls/status)
interface clock_panel_ctrl_if;
  import clock_panel_pkg::*;

  logic       btn_start_stop_i;
  logic       btn_step_i;
  logic       btn_speed_i;
  logic       clk_start_stop_o;
  logic       clk_step_o;
  logic       clk_speed_o;
  logic       running_o;
  speed_idx_t speed_idx_o;

  modport master (
    input  btn_start_stop_i, btn_step_i, btn_speed_i,
    output clk_start_stop_o, clk_step_o, clk_speed_o, running_o, speed_idx_o
  );

  modport slave (
    output btn_start_stop_i, btn_step_i, btn_speed_i,
    input  clk_start_stop_o, clk_step_o, clk_speed_o, running_o, speed_idx_o
  );
endinterface

// File: rtl/button_debounce.sv
// One push-button conditioner: 2-FF synchronizer, stability counter and
// accepted state, plus one-cycle press/release strobes.
// Ports: clk_i, rst_ni, btn_i (raw, asynchronous),
//        state_o (accepted level, 1 = pressed), press_o, release_o (strobes).
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic state_o,
  output logic press_o,
  output logic release_o
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          btn_in;
  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q;

  assign btn_in = ACTIVE_LOW ? ~btn_i : btn_i;

  // Synchronizer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sync_q <= 2'b00;
    else         sync_q <= {sync_q[0], btn_in};
  end

  // Count consecutive cycles the synchronized level disagrees with the
  // accepted one; any agreement restarts the count, so short bounces vanish.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q     <= '0;
      state_o   <= 1'b0;
      press_o   <= 1'b0;
      release_o <= 1'b0;
    end else begin
      press_o   <= 1'b0;
      release_o <= 1'b0;
      if (sync_q[1] != state_o) begin
        if (cnt_q == CNT_LAST) begin
          cnt_q     <= '0;
          state_o   <= sync_q[1];
          press_o   <= sync_q[1];
          release_o <= ~sync_q[1];
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

endmodule

// File: rtl/clock_panel_ctrl.sv
// Front-panel driver for the clock generator: debounces three buttons and
// produces fixed-width start/stop and speed pulses, a gated step level, and
// mirrors of the generator's run state and speed index.
// Ports: clk_i, rst_ni (async, active low), panel (clock_panel_ctrl_if.master).
module clock_panel_ctrl
  import clock_panel_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int unsigned PULSE_CYCLES    = PULSE_CYCLES_DEFAULT,
  parameter bit          BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  clock_panel_ctrl_if.master panel
);

  localparam int unsigned PW = $clog2(PULSE_CYCLES + 1);

  logic ss_state, ss_press, ss_release;
  logic st_state, st_press, st_release;
  logic sp_state, sp_press, sp_release;

  logic          ss_pulse_q, ss_pulse_d, sp_pulse_q, sp_pulse_d;
  logic [PW-1:0] ss_cnt_q, ss_cnt_d, sp_cnt_q, sp_cnt_d;
  logic          running_q, running_d;
  speed_idx_t    speed_q, speed_d;
  logic          armed_q, armed_d;
  logic          step_q, step_d;
  logic          ss_fire, sp_fire;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .ACTIVE_LOW(BTN_ACTIVE_LOW)) u_db_ss (
    .clk_i(clk_i), .rst_ni(rst_ni), .btn_i(panel.btn_start_stop_i),
    .state_o(ss_state), .press_o(ss_press), .release_o(ss_release));

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .ACTIVE_LOW(BTN_ACTIVE_LOW)) u_db_step (
    .clk_i(clk_i), .rst_ni(rst_ni), .btn_i(panel.btn_step_i),
    .state_o(st_state), .press_o(st_press), .release_o(st_release));

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .ACTIVE_LOW(BTN_ACTIVE_LOW)) u_db_speed (
    .clk_i(clk_i), .rst_ni(rst_ni), .btn_i(panel.btn_speed_i),
    .state_o(sp_state), .press_o(sp_press), .release_o(sp_release));

  // Level and release of the pulse-only buttons are not needed here.
  logic unused_btn;
  assign unused_btn = ^{ss_state, ss_release, sp_state, sp_release};

  // Next-state: pulse stretchers, run/speed mirrors and step gate.
  always_comb begin
    ss_fire    = ss_press && (ss_cnt_q == '0);
    sp_fire    = sp_press && (sp_cnt_q == '0);
    running_d  = running_q ^ ss_fire;
    speed_d    = speed_q + speed_idx_t'(sp_fire);
    ss_cnt_d   = ss_cnt_q;
    ss_pulse_d = 1'b0;
    sp_cnt_d   = sp_cnt_q;
    sp_pulse_d = 1'b0;
    armed_d    = armed_q;

    if (ss_fire) begin
      ss_cnt_d   = PW'(PULSE_CYCLES);
      ss_pulse_d = 1'b1;
    end else if (ss_cnt_q != '0) begin
      ss_cnt_d   = ss_cnt_q - PW'(1);
      ss_pulse_d = (ss_cnt_q > PW'(1));
    end

    if (sp_fire) begin
      sp_cnt_d   = PW'(PULSE_CYCLES);
      sp_pulse_d = 1'b1;
    end else if (sp_cnt_q != '0) begin
      sp_cnt_d   = sp_cnt_q - PW'(1);
      sp_pulse_d = (sp_cnt_q > PW'(1));
    end

    // Step only counts if pressed while stopped; running or release disarms
    // it, so a hold carried across a stop needs a fresh press.
    if (st_release || running_d) armed_d = 1'b0;
    else if (st_press)           armed_d = 1'b1;

    step_d = st_state & armed_d & ~running_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ss_cnt_q   <= '0;
      ss_pulse_q <= 1'b0;
      sp_cnt_q   <= '0;
      sp_pulse_q <= 1'b0;
      running_q  <= RUNNING_RESET;
      speed_q    <= SPEED_IDX_RESET;
      armed_q    <= 1'b0;
      step_q     <= 1'b0;
    end else begin
      ss_cnt_q   <= ss_cnt_d;
      ss_pulse_q <= ss_pulse_d;
      sp_cnt_q   <= sp_cnt_d;
      sp_pulse_q <= sp_pulse_d;
      running_q  <= running_d;
      speed_q    <= speed_d;
      armed_q    <= armed_d;
      step_q     <= step_d;
    end
  end

  assign panel.clk_start_stop_o = ss_pulse_q;
  assign panel.clk_speed_o      = sp_pulse_q;
  assign panel.clk_step_o       = step_q;
  assign panel.running_o        = running_q;
  assign panel.speed_idx_o      = speed_q;

endmodule

// File: tb/tb_clock_panel_ctrl.sv
// Scoreboard bench for clock_panel_ctrl (DEBOUNCE_CYCLES=8, PULSE_CYCLES=4,
// active-low buttons). Stimulus pushes expected output events (cycle and
// resulting state); a monitor pops and compares them as outputs change.
module tb_clock_panel_ctrl;
  import clock_panel_pkg::*;

  localparam int unsigned DB  = 8;
  localparam int unsigned PC  = 4;
  localparam int          LAT = 11;  // raw settle -> output edge

  typedef struct {
    int cyc;
    int val;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   checks   = 0;
  int   failures = 0;

  exp_t ss_q[$];
  exp_t sp_q[$];
  exp_t st_q[$];

  clock_panel_ctrl_if bus ();

  clock_panel_ctrl #(
    .DEBOUNCE_CYCLES(DB),
    .PULSE_CYCLES   (PC),
    .BTN_ACTIVE_LOW (1'b1)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .panel (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input int b, input logic v);
    case (b)
      0:       bus.btn_start_stop_i = v;
      1:       bus.btn_step_i       = v;
      default: bus.btn_speed_i      = v;
    endcase
  endtask

  task automatic press(input int b, input int hold);
    drive(b, 1'b0);
    tick(hold);
    drive(b, 1'b1);
    tick(20);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ss"},      int'(bus.clk_start_stop_o), 0);
    check({tag, "_speed"},   int'(bus.clk_speed_o),      0);
    check({tag, "_step"},    int'(bus.clk_step_o),       0);
    check({tag, "_running"}, int'(bus.running_o),        1);
    check({tag, "_idx"},     int'(bus.speed_idx_o),      0);
  endtask

  // Pops the expected event whenever an output edge appears; also checks
  // pulse widths and that the mirrors change on the pulse's rising edge.
  task automatic monitor();
    logic p_ss = 1'b0, p_sp = 1'b0, p_st = 1'b0, p_run = 1'b1;
    int   p_idx = 0;
    int   ss_rise = 0, sp_rise = 0;
    bit   ss_on = 1'b0, sp_on = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        ss_on = 1'b0;
        sp_on = 1'b0;
      end else begin
        if (bus.clk_start_stop_o && !p_ss) begin
          ss_on = 1'b1; ss_rise = cyc;
          if (ss_q.size() == 0) check("ss_unexpected_pulse", 1, 0);
          else begin
            e = ss_q.pop_front();
            check("ss_rise_cycle", cyc, e.cyc);
            check("running_after", int'(bus.running_o), e.val);
            check("running_before", int'(p_run), 1 - e.val);
          end
        end
        if (!bus.clk_start_stop_o && p_ss && ss_on) begin
          ss_on = 1'b0;
          check("ss_width", cyc - ss_rise, PC);
        end
        if (bus.clk_speed_o && !p_sp) begin
          sp_on = 1'b1; sp_rise = cyc;
          if (sp_q.size() == 0) check("sp_unexpected_pulse", 1, 0);
          else begin
            e = sp_q.pop_front();
            check("sp_rise_cycle", cyc, e.cyc);
            check("idx_after", int'(bus.speed_idx_o), e.val);
            check("idx_before", p_idx, (e.val + 3) % 4);
          end
        end
        if (!bus.clk_speed_o && p_sp && sp_on) begin
          sp_on = 1'b0;
          check("sp_width", cyc - sp_rise, PC);
        end
        if (bus.clk_step_o != p_st) begin
          if (st_q.size() == 0) check("step_unexpected_edge", 1, 0);
          else begin
            e = st_q.pop_front();
            check("step_edge_cycle", cyc, e.cyc);
            check("step_level", int'(bus.clk_step_o), e.val);
          end
        end
      end
      p_ss  = bus.clk_start_stop_o;
      p_sp  = bus.clk_speed_o;
      p_st  = bus.clk_step_o;
      p_run = bus.running_o;
      p_idx = int'(bus.speed_idx_o);
    end
  endtask

  initial begin
    bus.btn_start_stop_i = 1'b1;
    bus.btn_step_i       = 1'b1;
    bus.btn_speed_i      = 1'b1;
    fork
      monitor();
    join_none

    // Reset state, then idle with all buttons released.
    tick(3);
    check_reset_outputs("in_reset");
    rst_n = 1'b1;
    tick(50);
    check_reset_outputs("idle");

    // Start/stop press stops the clock.
    ss_q.push_back('{cyc + LAT, 0});
    press(0, 20);

    // Bouncing speed button is rejected; the following hold is one press.
    for (int i = 0; i < 10; i++) begin
      bus.btn_speed_i = ~bus.btn_speed_i;
      tick(3);
    end
    sp_q.push_back('{cyc + LAT, 1});
    press(2, 20);
    sp_q.push_back('{cyc + LAT, 2});
    press(2, 12);
    sp_q.push_back('{cyc + LAT, 3});
    press(2, 12);
    sp_q.push_back('{cyc + LAT, 0});
    press(2, 12);

    // Step while stopped, then start and try step while running.
    st_q.push_back('{cyc + LAT, 1});
    st_q.push_back('{cyc + 30 + LAT, 0});
    press(1, 30);
    ss_q.push_back('{cyc + LAT, 1});
    press(0, 12);
    press(1, 30);

    // Stop, hold step, then start+speed together.
    ss_q.push_back('{cyc + LAT, 0});
    press(0, 12);
    st_q.push_back('{cyc + LAT, 1});
    drive(1, 1'b0);
    tick(15);
    ss_q.push_back('{cyc + LAT, 1});
    sp_q.push_back('{cyc + LAT, 1});
    st_q.push_back('{cyc + LAT, 0});
    drive(0, 1'b0);
    drive(2, 1'b0);
    tick(15);
    drive(0, 1'b1);
    drive(2, 1'b1);
    tick(20);
    // Stop with step still held: step must stay low.
    ss_q.push_back('{cyc + LAT, 0});
    press(0, 12);
    drive(1, 1'b1);
    tick(20);

    // Reset two cycles into a speed pulse, speed button held through it.
    sp_q.push_back('{cyc + LAT, 2});
    drive(2, 1'b0);
    tick(13);
    check("speed_pulse_before_reset", int'(bus.clk_speed_o), 1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    tick(3);
    rst_n = 1'b1;
    sp_q.push_back('{cyc + LAT, 1});
    tick(20);
    drive(2, 1'b1);
    tick(20);

    check("ss_events_left", ss_q.size(), 0);
    check("sp_events_left", sp_q.size(), 0);
    check("st_events_left", st_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
